// File: rtl/stopwatch_lap_timer_pkg.sv
// Shared types and sizing helpers for the stopwatch/lap timer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE = 2'd0,
    SW_RUN  = 2'd1,
    SW_DONE = 2'd2
  } sw_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_LAP_DEPTH  = 4;

  // Pointer width for a power-of-two lap FIFO depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stopwatch_lap_timer_if.sv
// Control, count and lap-drain signals of the stopwatch grouped as one bundle.
interface stopwatch_lap_timer_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  lap;
  logic                  down;
  logic [DATA_WIDTH-1:0] max_val;
  logic [DATA_WIDTH-1:0] count;
  logic                  running;
  logic                  terminal;
  logic [DATA_WIDTH-1:0] lap_data;
  logic                  lap_valid;
  logic                  lap_ready;
  logic                  lap_overflow;

  modport master (
    output start, stop, clear, lap, down, max_val, lap_ready,
    input  count, running, terminal, lap_data, lap_valid, lap_overflow
  );

  modport slave (
    input  start, stop, clear, lap, down, max_val, lap_ready,
    output count, running, terminal, lap_data, lap_valid, lap_overflow
  );
endinterface

// File: rtl/stopwatch_lap_timer_lap_fifo.sv
// Synchronous lap-capture FIFO; head is zero while empty.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int unsigned AW = ptr_width(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; flush empties the FIFO and discards same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until covered by the pointers.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch/countdown timer with prescaler, runtime limit and lap FIFO.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned LAP_DEPTH  = 4,
  parameter int unsigned WRAP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  stopwatch_lap_timer_if.slave  bus
);
  localparam int unsigned DW      = DATA_WIDTH;
  localparam int unsigned PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam bit          WRAP_EN = (WRAP != 0);

  sw_state_e     state;
  logic [DW-1:0] count;
  logic [PW-1:0] pre_cnt;
  logic          terminal;
  logic          overflow;
  logic          active_c;
  logic          tick_c;
  logic          limit_c;
  logic [DW-1:0] next_count_c;
  logic          fifo_full;
  logic          fifo_empty;

  // Counting proceeds in RUN or on the cycle a start is accepted from IDLE.
  assign active_c = !bus.stop && ((state == SW_RUN) || ((state == SW_IDLE) && bus.start));
  assign tick_c   = active_c && (pre_cnt == PW'(PRESCALE - 1));

  // Next count on a tick and whether that tick wraps or saturates.
  always_comb begin
    next_count_c = count;
    limit_c      = 1'b0;
    if (!bus.down) begin
      if (count >= bus.max_val) begin
        limit_c      = 1'b1;
        next_count_c = WRAP_EN ? '0 : bus.max_val;
      end else begin
        next_count_c = count + DW'(1);
      end
    end else if (count == '0) begin
      limit_c      = 1'b1;
      next_count_c = WRAP_EN ? bus.max_val : '0;
    end else if (count > bus.max_val) begin
      next_count_c = bus.max_val;
    end else begin
      next_count_c = count - DW'(1);
    end
  end

  // State machine, prescaler, counter, terminal pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state    <= SW_IDLE;
      count    <= '0;
      pre_cnt  <= '0;
      terminal <= 1'b0;
      overflow <= 1'b0;
    end else begin
      terminal <= 1'b0;
      // Full FIFO only accepts a lap when the consumer pops the same cycle.
      if (bus.lap && fifo_full && !bus.lap_ready) overflow <= 1'b1;
      if (bus.stop) begin
        if (state == SW_RUN) state <= SW_IDLE;
      end else begin
        if ((state == SW_IDLE) && bus.start) state <= SW_RUN;
        if (active_c) begin
          pre_cnt <= tick_c ? '0 : pre_cnt + PW'(1);
        end
        if (tick_c) begin
          count    <= next_count_c;
          terminal <= limit_c;
          if (limit_c && !WRAP_EN) state <= SW_DONE;
        end
      end
    end
  end

  lap_fifo #(
    .DW    (DW),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.clear),
    .push  (bus.lap),
    .pop   (bus.lap_ready),
    .din   (count),
    .dout  (bus.lap_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.count        = count;
  assign bus.running      = (state == SW_RUN);
  assign bus.terminal     = terminal;
  assign bus.lap_valid    = !fifo_empty;
  assign bus.lap_overflow = overflow;
endmodule
